obj_linebuf: RTL and testbench

Sprite line buffer that sits directly downstream of the sprite address/control stage and the sprite graphics ROMs. During line N it accepts 8-pixel, 4bpp graphics words for each sprite that the upstream stage flags as on-line, and composites them into one half of a ping-pong 256-pixel buffer, with transparency and first-come priority. It simultaneously reads out the other half, which holds line N-1, to the video mixer, and clears each location as it is read.

---
 rtl/obj_linebuf.sv | 127 ++++++++++++
 tb/tb_obj_linebuf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/obj_linebuf.sv
`default_nettype none
// obj_linebuf: ping-pong sprite line buffer. Composites 8-pixel 4bpp sprite words into
// the write bank while the read bank streams the previous line out, clearing as it goes.
module obj_linebuf #(
    parameter int XW = 8,
    parameter int CW = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            CEN,
    input  logic            LINE_START,
    input  logic [XW-1:0]   HCNT,
    input  logic            OCS_N,
    input  logic            GFX_VALID,
    input  logic [31:0]     GFX,
    input  logic [XW-1:0]   XPOS,
    input  logic [CW-1:0]   COLOR,
    input  logic            HFLIP,
    output logic            BUSY,
    output logic [CW+3:0]   PIX
);

    localparam int DEPTH = 1 << XW;
    localparam int PW    = CW + 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state;
    logic            sel;
    logic            primed;
    logic [2:0]      idx;
    logic [31:0]     gfx_q;
    logic [XW-1:0]   xpos_q;
    logic [CW-1:0]   color_q;
    logic            hflip_q;

    logic [PW-1:0]   mem [2][DEPTH];

    logic            swap;
    logic            rd_bank;
    logic            wr_bank;
    logic [2:0]      nib;
    logic [3:0]      pix_val;
    logic [XW:0]     wr_x;
    logic            wr_en;

    assign swap    = CEN & LINE_START;
    // On a swap edge the read already targets the bank that was just filled.
    assign rd_bank = swap ? ~sel : sel;
    assign wr_bank = ~sel;

    // Nibble n lives at bits [31-4n -: 4]; for a 3-bit n, 7-n is simply ~n.
    assign nib     = hflip_q ? (3'd7 - idx) : idx;
    assign pix_val = gfx_q[{~nib, 2'b00} +: 4];
    assign wr_x    = {1'b0, xpos_q} + {{(XW-2){1'b0}}, idx};

    assign wr_en   = (state == WRITE) && !swap && (pix_val != 4'd0) && !wr_x[XW]
                     && (mem[wr_bank][wr_x[XW-1:0]][3:0] == 4'd0);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_bank][wr_x[XW-1:0]] <= {color_q, pix_val};
        end
        if (CEN) begin
            mem[rd_bank][HCNT] <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            BUSY    <= 1'b0;
            PIX     <= '0;
            sel     <= 1'b0;
            primed  <= 1'b0;
            idx     <= 3'd0;
            gfx_q   <= '0;
            xpos_q  <= '0;
            color_q <= '0;
            hflip_q <= 1'b0;
        end else begin
            if (CEN) begin
                PIX <= primed ? mem[rd_bank][HCNT] : '0;
                if (LINE_START) begin
                    sel    <= ~sel;
                    primed <= 1'b1;
                end
            end

            if (swap) begin
                state <= IDLE;
                BUSY  <= 1'b0;
                idx   <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (GFX_VALID && !OCS_N) begin
                            gfx_q   <= GFX;
                            xpos_q  <= XPOS;
                            color_q <= COLOR;
                            hflip_q <= HFLIP;
                            idx     <= 3'd0;
                            state   <= WRITE;
                            BUSY    <= 1'b1;
                        end
                    end
                    WRITE: begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obj_linebuf.sv
`default_nettype none
// tb_obj_linebuf: directed, table-driven checks of obj_linebuf compositing and readout.
module tb_obj_linebuf;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CEN = 1'b0;
    logic        LINE_START = 1'b0;
    logic [7:0]  HCNT = 8'h00;
    logic        OCS_N = 1'b1;
    logic        GFX_VALID = 1'b0;
    logic [31:0] GFX = 32'h0;
    logic [7:0]  XPOS = 8'h00;
    logic [3:0]  COLOR = 4'h0;
    logic        HFLIP = 1'b0;
    logic        BUSY;
    logic [7:0]  PIX;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  xpos;
        logic [3:0]  color;
        logic [31:0] gfx;
        logic        hflip;
        logic        ocs_n;
        int          busy_cycles;
    } word_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] pix;
    } pt_t;

    logic [7:0] exp_line [256];

    always #5 CLK = ~CLK;

    obj_linebuf #(.XW(8), .CW(4)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .CEN        (CEN),
        .LINE_START (LINE_START),
        .HCNT       (HCNT),
        .OCS_N      (OCS_N),
        .GFX_VALID  (GFX_VALID),
        .GFX        (GFX),
        .XPOS       (XPOS),
        .COLOR      (COLOR),
        .HFLIP      (HFLIP),
        .BUSY       (BUSY),
        .PIX        (PIX)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input word_t w);
        int cnt;
        XPOS      = w.xpos;
        COLOR     = w.color;
        GFX       = w.gfx;
        HFLIP     = w.hflip;
        OCS_N     = w.ocs_n;
        GFX_VALID = 1'b1;
        tick();
        GFX_VALID = 1'b0;
        OCS_N     = 1'b1;
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        check("busy_cycles", cnt, w.busy_cycles);
    endtask

    task automatic do_swap;
        HCNT       = 8'h00;
        CEN        = 1'b1;
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        CEN        = 1'b0;
    endtask

    task automatic read_line(input bit do_check, input string tag);
        for (int x = 0; x < 256; x++) begin
            HCNT = 8'(x);
            CEN  = 1'b1;
            tick();
            if (do_check) check($sformatf("%s_pix_x%02h", tag, x), PIX, exp_line[x]);
        end
        CEN = 1'b0;
    endtask

    task automatic clear_exp;
        for (int x = 0; x < 256; x++) exp_line[x] = 8'h00;
    endtask

    initial begin
        word_t words [6];
        pt_t   pts   [26];

        // Line-1 sprite words and their expected BUSY lengths.
        words[0] = '{8'h10, 4'h5, 32'h12345678, 1'b0, 1'b0, 8};  // single sprite
        words[1] = '{8'h40, 4'h3, 32'h10000002, 1'b1, 1'b0, 8};  // flip + transparency
        words[2] = '{8'h20, 4'h1, 32'h11110000, 1'b0, 1'b0, 8};  // priority A
        words[3] = '{8'h22, 4'h2, 32'h22222222, 1'b0, 1'b0, 8};  // priority B
        words[4] = '{8'h80, 4'h7, 32'h77777777, 1'b0, 1'b1, 0};  // OCS_N high: dropped
        words[5] = '{8'hFC, 4'h6, 32'hFFFFFFFF, 1'b0, 1'b0, 8};  // right edge

        pts[0]  = '{8'h10, 8'h51}; pts[1]  = '{8'h11, 8'h52}; pts[2]  = '{8'h12, 8'h53};
        pts[3]  = '{8'h13, 8'h54}; pts[4]  = '{8'h14, 8'h55}; pts[5]  = '{8'h15, 8'h56};
        pts[6]  = '{8'h16, 8'h57}; pts[7]  = '{8'h17, 8'h58};
        pts[8]  = '{8'h40, 8'h32}; pts[9]  = '{8'h47, 8'h31};
        pts[10] = '{8'h20, 8'h11}; pts[11] = '{8'h21, 8'h11}; pts[12] = '{8'h22, 8'h11};
        pts[13] = '{8'h23, 8'h11}; pts[14] = '{8'h24, 8'h22}; pts[15] = '{8'h25, 8'h22};
        pts[16] = '{8'h26, 8'h22}; pts[17] = '{8'h27, 8'h22}; pts[18] = '{8'h28, 8'h22};
        pts[19] = '{8'h29, 8'h22};
        pts[20] = '{8'hFC, 8'h6F}; pts[21] = '{8'hFD, 8'h6F}; pts[22] = '{8'hFE, 8'h6F};
        pts[23] = '{8'hFF, 8'h6F};
        pts[24] = '{8'h00, 8'h00}; pts[25] = '{8'h80, 8'h00};

        // Reset state
        #12;
        check("reset_busy", BUSY, 1'b0);
        check("reset_pix", PIX, 8'h00);
        tick();
        RESET_N = 1'b1;
        tick();

        // Flush both banks so later compositing starts from transparent storage.
        do_swap();
        read_line(1'b0, "init1");
        do_swap();
        read_line(1'b0, "init2");

        // Line 1: composite the word table, then read it back.
        for (int i = 0; i < 6; i++) send_word(words[i]);
        do_swap();
        clear_exp();
        for (int i = 0; i < 26; i++) exp_line[pts[i].x] = pts[i].pix;
        read_line(1'b1, "line1");

        // PIX holds between CEN cycles.
        HCNT = 8'h10;
        tick();
        tick();
        check("pix_hold", PIX, 8'h6F);

        // Reset in the middle of a write.
        XPOS = 8'h50; COLOR = 4'h9; GFX = 32'h99999999; HFLIP = 1'b0; OCS_N = 1'b0;
        GFX_VALID = 1'b1;
        tick();
        GFX_VALID = 1'b0; OCS_N = 1'b1;
        tick(); tick(); tick();
        check("midwrite_busy", BUSY, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset_busy", BUSY, 1'b0);
        check("async_reset_pix", PIX, 8'h00);
        tick();
        RESET_N = 1'b1;
        clear_exp();
        read_line(1'b1, "unprimed");

        // Swap in the middle of a write: LINE_START at edge N+3.
        do_swap();
        XPOS = 8'h30; COLOR = 4'h7; GFX = 32'h12345678; HFLIP = 1'b0; OCS_N = 1'b0;
        GFX_VALID = 1'b1;
        tick();
        GFX_VALID = 1'b0; OCS_N = 1'b1;
        tick(); tick();
        check("pre_swap_busy", BUSY, 1'b1);
        HCNT = 8'h00; CEN = 1'b1; LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0; CEN = 1'b0;
        check("swap_abort_busy", BUSY, 1'b0);
        tick();
        check("swap_idle_busy", BUSY, 1'b0);
        clear_exp();
        exp_line[8'h30] = 8'h71;
        exp_line[8'h31] = 8'h72;
        read_line(1'b1, "trunc");

        // Line after a full readout is entirely clear.
        do_swap();
        clear_exp();
        read_line(1'b1, "cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
